pc_array_rr: RTL and testbench
==============================

Name: pc_array_rr

Overview:
Multi-thread program-counter file with a built-in round-robin thread scheduler for the fetch stage. Each cycle it picks the next eligible hardware thread, issues that thread's PC to fetch through a registered output, and advances the PC by a programmable stride. A redirect port lets a later pipeline stage (branch/jump resolution) overwrite any thread's PC. A stall input freezes issue. Successor to the single-increment PC array: it adds thread masking, scheduling, redirect, stall and a configurable reset vector and stride.

Parameters:
THREAD_INDEX_BITS, 3, log2 of thread count; NT = 2**THREAD_INDEX_BITS
PC_WIDTH, 8, program counter width in bits
PC_STRIDE, 1, increment added per issue; must be less than 2**PC_WIDTH
RESET_PC, 0, value loaded into every PC at reset

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
in_thread_enable  input  NT  bit t=1 makes thread t eligible for issue
in_stall  input  1  1 = hold issue state and outputs
in_redirect_valid  input  1  redirect request this cycle
in_redirect_thread  input  THREAD_INDEX_BITS  thread being redirected
in_redirect_pc  input  PC_WIDTH  new PC for that thread
out_valid  output  1  issued slot valid
out_thread_index  output  THREAD_INDEX_BITS  thread of issued slot
out_program_counter  output  PC_WIDTH  PC of issued slot

Behaviour:
- Reset (reset_n=0, asynchronous, any time, including mid-run): all PC[t]=RESET_PC, last-issued pointer=NT-1, out_valid=0, out_thread_index=0, out_program_counter=0. The first issue after release is the lowest eligible thread index.
- Eligibility: thread t is eligible when in_thread_enable[t]=1 and not (in_redirect_valid=1 and in_redirect_thread=t).
- Selection: search for an eligible thread starting at pointer+1, wrapping modulo NT. The pointer itself is searched last, so a sole eligible thread issues every cycle.
- Issue, on the clock edge when in_stall=0 and at least one thread is eligible (winner s):
  - out_valid<=1, out_thread_index<=s, out_program_counter<=PC[s] (pre-increment value).
  - PC[s]<=(PC[s]+PC_STRIDE) mod 2**PC_WIDTH; wrap is silent.
  - pointer<=s.
  - Latency is 1 cycle from selection to output.
- No eligible thread and in_stall=0: out_valid<=0. Thread and PC outputs and the pointer hold.
- in_stall=1: out_valid, out_thread_index, out_program_counter, the pointer and all PCs hold, except that a redirect still applies.
- Redirect: when in_redirect_valid=1, PC[in_redirect_thread]<=in_redirect_pc on that edge, whether or not stalled. Because the redirected thread is ineligible that cycle, increment and redirect never collide. Redirect has priority. The thread issues from the new PC no earlier than the next cycle.
- Redirect does not alter the current registered output. Flushing an in-flight slot is downstream's job.
- Enable mask changes take effect for the selection made in the same cycle. A disabled thread's PC is retained.
- A single redirect port is provided. A simultaneous redirect and issue to different threads both apply.

Decomposition:
- Shared package pc_pkg:
  - NUM_THREADS derived from THREAD_INDEX_BITS.
  - thread_idx_t and pc_t typedefs.
  - RESET_PC and PC_STRIDE defaults.
- Sub-module rr_arbiter (NT-wide request vector, pointer input, one-hot grant plus encoded index, any_grant). It is purely combinational and reusable by later issue/writeback arbiters.
- The top level holds the PC storage, the pointer and the output registers.

Test Plan:
- Reset, all enables=0xFF, no stall, 10 cycles -> out_thread_index 0,1,...,7,0,1. PCs are 0 for the first eight slots and 1 for the next two; out_valid=1 from the first edge after reset release.
- Enable=0b00100100 -> issue alternates 2,5,2,5 with PCs 0,0,1,1. Then enable=0 -> out_valid=0 with the previous index/PC held. Re-enable -> issue resumes at the next thread after the last issued.
- Stall for 3 cycles mid-stream -> outputs frozen, no PC advance. Release -> sequence continues with no skipped or duplicated slot.
- Only thread 3 enabled; redirect thread 3 to 0x40 -> out_valid=0 that cycle. The next issue is thread 3 with PC 0x40, then 0x41.
- PC_STRIDE=4, PC_WIDTH=8; thread 0 redirected to 0xFC, only thread 0 enabled -> issued PCs 0xFC, 0x00, 0x04.
- Assert reset_n low asynchronously mid-cycle during an issue -> outputs clear immediately with no clock edge. After release, thread 0 issues RESET_PC.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared thread/PC sizing defaults and typedefs for the multi-thread fetch PC file.
package pc_pkg;
    localparam int THREAD_INDEX_BITS = 3;
    localparam int NUM_THREADS       = 2 ** THREAD_INDEX_BITS;
    localparam int PC_WIDTH          = 8;
    localparam int PC_STRIDE         = 1;
    localparam int RESET_PC          = 0;

    typedef logic [THREAD_INDEX_BITS-1:0] thread_idx_t;
    typedef logic [PC_WIDTH-1:0]          pc_t;
    typedef logic [NUM_THREADS-1:0]       thread_mask_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, searching from ptr+1 upward with ptr itself last.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the most recent winner
//   grant - one-hot grant
//   idx   - encoded index of the granted requester
//   any   - at least one request was granted
module rr_arbiter
    import pc_pkg::*;
#(
    parameter int N  = NUM_THREADS,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] c;

    // Walk from the farthest candidate (ptr itself) to the nearest (ptr+1) so the
    // nearest requester overwrites earlier hits. N is a power of two, so the
    // IW-bit add wraps modulo N for free.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = '0;
        for (int i = N; i >= 1; i--) begin
            c = ptr + IW'(i);
            if (req[c]) begin
                grant    = '0;
                grant[c] = 1'b1;
                idx      = c;
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pc_array_rr.sv
// pc_array_rr: per-thread PC file with round-robin fetch issue, stride advance, redirect and stall.
// Ports:
//   clk, reset_n         - clock and asynchronous active-low reset
//   in_thread_enable     - per-thread issue eligibility mask
//   in_stall             - freeze issue state and outputs (redirect still lands)
//   in_redirect_*        - overwrite one thread's PC; that thread sits out this cycle's selection
//   out_valid            - registered issue slot valid
//   out_thread_index     - thread of the issued slot
//   out_program_counter  - pre-increment PC of the issued slot
module pc_array_rr
    import pc_pkg::*;
#(
    parameter int THREAD_INDEX_BITS = pc_pkg::THREAD_INDEX_BITS,
    parameter int PC_WIDTH          = pc_pkg::PC_WIDTH,
    parameter int PC_STRIDE         = pc_pkg::PC_STRIDE,
    parameter int RESET_PC          = pc_pkg::RESET_PC
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [2**THREAD_INDEX_BITS-1:0] in_thread_enable,
    input  logic                         in_stall,
    input  logic                         in_redirect_valid,
    input  logic [THREAD_INDEX_BITS-1:0] in_redirect_thread,
    input  logic [PC_WIDTH-1:0]          in_redirect_pc,
    output logic                         out_valid,
    output logic [THREAD_INDEX_BITS-1:0] out_thread_index,
    output logic [PC_WIDTH-1:0]          out_program_counter
);
    localparam int NT = 2 ** THREAD_INDEX_BITS;

    logic [PC_WIDTH-1:0]          pc [NT];
    logic [THREAD_INDEX_BITS-1:0] ptr;
    logic [NT-1:0]                eligible;
    logic [NT-1:0]                grant;
    logic [THREAD_INDEX_BITS-1:0] sel;
    logic                         any;

    // A thread being redirected is masked out, so increment and redirect never target the same PC.
    always_comb begin
        eligible = in_thread_enable & ~(in_redirect_valid ? (NT'(1) << in_redirect_thread) : '0);
    end

    rr_arbiter #(
        .N  (NT),
        .IW (THREAD_INDEX_BITS)
    ) u_arb (
        .req   (eligible),
        .ptr   (ptr),
        .grant (grant),
        .idx   (sel),
        .any   (any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr                 <= THREAD_INDEX_BITS'(NT - 1);
            out_valid           <= 1'b0;
            out_thread_index    <= '0;
            out_program_counter <= '0;
        end else if (!in_stall) begin
            out_valid <= any;
            if (any) begin
                ptr                 <= sel;
                out_thread_index    <= sel;
                out_program_counter <= pc[sel];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < NT; t++) pc[t] <= PC_WIDTH'(RESET_PC);
        end else begin
            for (int t = 0; t < NT; t++) begin
                if (in_redirect_valid && in_redirect_thread == THREAD_INDEX_BITS'(t))
                    pc[t] <= in_redirect_pc;
                else if (!in_stall && grant[t])
                    pc[t] <= pc[t] + PC_WIDTH'(PC_STRIDE);
            end
        end
    end
endmodule

// File: tb/tb_pc_array_rr.sv
// tb_pc_array_rr: directed plus random check of two pc_array_rr instances (stride 1 and 4) against a reference model.
module tb_pc_array_rr;
    import pc_pkg::*;

    localparam int NT = NUM_THREADS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [NT-1:0] en = '0;
    logic          stall = 1'b0;
    logic          rv = 1'b0;
    logic [2:0]    rt = '0;
    logic [7:0]    rpc = '0;

    logic       v1, v4;
    logic [2:0] t1, t4;
    logic [7:0] p1, p4;

    int n_cmp = 0;
    int n_err = 0;

    int mpc [2][NT];
    int mptr [2];
    int mv [2];
    int mt [2];
    int mp [2];

    always #5 clk = ~clk;

    pc_array_rr dut1 (
        .clk(clk), .reset_n(reset_n), .in_thread_enable(en), .in_stall(stall),
        .in_redirect_valid(rv), .in_redirect_thread(rt), .in_redirect_pc(rpc),
        .out_valid(v1), .out_thread_index(t1), .out_program_counter(p1)
    );

    pc_array_rr #(.PC_STRIDE(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_thread_enable(en), .in_stall(stall),
        .in_redirect_valid(rv), .in_redirect_thread(rt), .in_redirect_pc(rpc),
        .out_valid(v4), .out_thread_index(t4), .out_program_counter(p4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < NT; t++) mpc[k][t] = RESET_PC;
            mptr[k] = NT - 1;
            mv[k] = 0;
            mt[k] = 0;
            mp[k] = 0;
        end
    endfunction

    // One clock edge of the fetch scheduler, evaluated from the current inputs.
    function automatic void model_clock();
        for (int k = 0; k < 2; k++) begin
            int stride = (k == 1) ? 4 : 1;
            if (!stall) begin
                int s = -1;
                for (int i = 1; i <= NT; i++) begin
                    int t = (mptr[k] + i) % NT;
                    if (s < 0 && en[t] && !(rv && int'(rt) == t)) s = t;
                end
                if (s >= 0) begin
                    mv[k] = 1;
                    mt[k] = s;
                    mp[k] = mpc[k][s];
                    mpc[k][s] = (mpc[k][s] + stride) % 256;
                    mptr[k] = s;
                end else begin
                    mv[k] = 0;
                end
            end
            if (rv) mpc[k][rt] = rpc;
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, " s1 valid"}, 32'(v1), mv[0]);
        check({tag, " s1 thread"}, 32'(t1), mt[0]);
        check({tag, " s1 pc"}, 32'(p1), mp[0]);
        check({tag, " s4 valid"}, 32'(v4), mv[1]);
        check({tag, " s4 thread"}, 32'(t4), mt[1]);
        check({tag, " s4 pc"}, 32'(p4), mp[1]);
    endtask

    task automatic step(input string tag);
        model_clock();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle();
        stall = 1'b0;
        rv = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        #2 compare_all("reset");
        @(posedge clk);
        #1 compare_all("reset_hold");
        reset_n = 1'b1;

        en = 8'hFF;
        for (int i = 0; i < 10; i++) step("all_en");

        en = 8'b0010_0100;
        for (int i = 0; i < 4; i++) step("mask_2_5");
        en = 8'h00;
        for (int i = 0; i < 2; i++) step("none_en");
        en = 8'hFF;
        for (int i = 0; i < 3; i++) step("reenable");

        stall = 1'b1;
        for (int i = 0; i < 3; i++) step("stall");
        stall = 1'b0;
        for (int i = 0; i < 4; i++) step("unstall");

        en = 8'b0000_1000;
        rv = 1'b1; rt = 3'd3; rpc = 8'h40;
        step("redir_t3");
        rv = 1'b0;
        for (int i = 0; i < 2; i++) step("after_redir_t3");

        en = 8'b0000_0001;
        rv = 1'b1; rt = 3'd0; rpc = 8'hFC;
        step("redir_t0");
        rv = 1'b0;
        for (int i = 0; i < 3; i++) step("wrap");

        en = 8'hFF;
        step("pre_async");
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1 compare_all("async_rst_hold");
        reset_n = 1'b1;
        en = 8'h01;
        step("post_rst_t0");

        for (int i = 0; i < 500; i++) begin
            en    = NT'($urandom);
            stall = ($urandom_range(3) == 0);
            rv    = ($urandom_range(2) == 0);
            rt    = 3'($urandom);
            rpc   = 8'($urandom);
            step("random");
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
